// File: rtl/link_latency_monitor.sv
// Link latency monitor: counter/IDLE pattern generator plus loopback checker.
// Measures tx-to-rx latency in cycles and flags alignment and K-code faults.
module link_latency_monitor #(
  parameter int unsigned g_BYTES               = 2,
  parameter logic [7:0]  g_COMMA               = 8'hBC,
  parameter logic [7:0]  g_FILL                = 8'h95,
  parameter int unsigned g_IDLE_PERIOD         = 193,
  parameter int unsigned g_BLIND_PERIOD        = 10,
  parameter int unsigned g_NUM_SUCCESSFUL_DATA = 1000,
  parameter int unsigned g_MAX_LATENCY         = 64
) (
  input  logic                   usrclk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  output logic [8*g_BYTES-1:0]   tx_data_o,
  output logic [g_BYTES-1:0]     tx_k_o,
  input  logic [8*g_BYTES-1:0]   rx_data_i,
  input  logic [g_BYTES-1:0]     rx_k_i,
  output logic                   rx_realign_o,
  input  logic                   rx_aligned_i,
  output logic                   pass_o,
  output logic                   fail_o,
  output logic [1:0]             fail_code_o,
  output logic [15:0]            latency_min_o,
  output logic [15:0]            latency_max_o,
  output logic [31:0]            good_cnt_o
);

  localparam int W  = 8 * g_BYTES;
  localparam int PW =
    (g_IDLE_PERIOD > 1) ? $clog2(g_IDLE_PERIOD) : 1;
  localparam int BW =
    (g_BLIND_PERIOD > 1) ? $clog2(g_BLIND_PERIOD) : 1;

  localparam logic [PW-1:0] PER_LAST =
    PW'(g_IDLE_PERIOD - 1);
  localparam logic [BW-1:0] BLIND_LAST =
    BW'(g_BLIND_PERIOD - 1);
  localparam logic [W-1:0] IDLE_WORD =
    {g_COMMA, {(g_BYTES-1){g_FILL}}};
  localparam logic [g_BYTES-1:0] IDLE_K =
    {1'b1, {(g_BYTES-1){1'b0}}};
  localparam logic [W-1:0]  MAX_LAT  = W'(g_MAX_LATENCY);
  localparam logic [31:0]   PASS_CNT = 32'(g_NUM_SUCCESSFUL_DATA);

  typedef enum logic [2:0] {
    S_OFF,
    S_REALIGN,
    S_BLIND,
    S_WAIT_COMMA,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [W-1:0]    cnt;
  logic [PW-1:0]   per;
  logic [BW-1:0]   blind;
  logic [BW-1:0]   blind_n;
  logic [31:0]     good_n;
  logic [15:0]     min_n;
  logic [15:0]     max_n;
  logic [1:0]      code_n;
  logic [W-1:0]    lat;
  logic            idle_ok;
  logic            comma_lo;
  logic            k_bad;
  logic            tracking;

  // Generator runs regardless of the checker state.
  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      per       <= '0;
      tx_data_o <= '0;
      tx_k_o    <= '0;
    end else begin
      cnt <= cnt + W'(1);
      per <= (per == PER_LAST) ? '0 : per + PW'(1);
      if (per == '0) begin
        tx_k_o    <= IDLE_K;
        tx_data_o <= IDLE_WORD;
      end else begin
        tx_k_o    <= '0;
        tx_data_o <= cnt;
      end
    end
  end

  always_comb begin
    state_n  = state;
    blind_n  = blind;
    good_n   = good_cnt_o;
    min_n    = latency_min_o;
    max_n    = latency_max_o;
    code_n   = fail_code_o;
    lat      = tx_data_o - rx_data_i;
    idle_ok  = (rx_k_i == IDLE_K) && (rx_data_i == IDLE_WORD);
    k_bad    = (rx_k_i != '0) && !idle_ok;
    comma_lo = 1'b0;
    for (int i = 0; i < int'(g_BYTES) - 1; i++) begin
      if (rx_k_i[i] && rx_data_i[8*i +: 8] == g_COMMA)
        comma_lo = 1'b1;
    end
    tracking = (state == S_BLIND) || (state == S_WAIT_COMMA) ||
               (state == S_CHECK) || (state == S_PASS);

    if (clear_i) begin
      state_n = S_OFF;
      blind_n = '0;
      good_n  = '0;
      min_n   = 16'hFFFF;
      max_n   = '0;
      code_n  = 2'd0;
    end else if (state != S_FAIL) begin
      if (!enable_i) begin
        state_n = S_OFF;
      end else if (tracking && !rx_aligned_i) begin
        state_n = S_REALIGN;
        blind_n = '0;
        good_n  = '0;
      end else begin
        unique case (state)
          S_OFF: state_n = S_REALIGN;
          S_REALIGN: begin
            if (rx_aligned_i) begin
              state_n = S_BLIND;
              blind_n = '0;
            end
          end
          S_BLIND: begin
            if (blind == BLIND_LAST) begin
              state_n = S_WAIT_COMMA;
              blind_n = '0;
            end else begin
              blind_n = blind + BW'(1);
            end
          end
          S_WAIT_COMMA, S_CHECK, S_PASS: begin
            if (k_bad) begin
              state_n = S_FAIL;
              code_n  = comma_lo ? 2'd1 : 2'd2;
            end else if (state == S_WAIT_COMMA) begin
              if (idle_ok) state_n = S_CHECK;
            end else if (rx_k_i == '0 && tx_k_o == '0) begin
              if (lat > MAX_LAT) begin
                state_n = S_FAIL;
                code_n  = 2'd3;
              end else begin
                if (lat[15:0] < latency_min_o) min_n = lat[15:0];
                if (lat[15:0] > latency_max_o) max_n = lat[15:0];
                if (good_cnt_o != '1) good_n = good_cnt_o + 32'd1;
                if (state == S_CHECK && good_n >= PASS_CNT)
                  state_n = S_PASS;
              end
            end
          end
          default: state_n = S_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      state         <= S_OFF;
      blind         <= '0;
      rx_realign_o  <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      fail_code_o   <= 2'd0;
      latency_min_o <= 16'hFFFF;
      latency_max_o <= '0;
      good_cnt_o    <= '0;
    end else begin
      state         <= state_n;
      blind         <= blind_n;
      rx_realign_o  <= (state_n == S_REALIGN);
      pass_o        <= (state_n == S_PASS);
      fail_o        <= (state_n == S_FAIL);
      fail_code_o   <= code_n;
      latency_min_o <= min_n;
      latency_max_o <= max_n;
      good_cnt_o    <= good_n;
    end
  end

endmodule
